// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, line field offsets and refill engine state encoding.
package cache_pkg;
   localparam int INDEX_W   = 6;
   localparam int OFFSET_W  = 4;
   localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
   localparam int WORD_W    = 32;
   localparam int BEATS     = (2 ** OFFSET_W) * 8 / WORD_W;
   localparam int CNT_W     = $clog2(BEATS);
   localparam int LINE_W    = 1 + TAG_W + BEATS * WORD_W;
   localparam int VALID_BIT = LINE_W - 1;
   localparam int TAG_MSB   = LINE_W - 2;
   localparam int TAG_LSB   = BEATS * WORD_W;
   typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, INV} state_t;
endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: burst-refills one cache line on a miss and sweeps the array on invalidate.
module cache_refill_ctrl
   import cache_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      miss_req,
   input  logic [31:0]               miss_addr,
   output logic                      miss_ready,
   input  logic                      inv_req,
   output logic                      mem_rd_req,
   output logic [31:0]               mem_rd_addr,
   input  logic                      mem_rd_ready,
   input  logic                      mem_rd_valid,
   input  logic [WORD_W-1:0]         mem_rd_data,
   input  logic                      mem_rd_last,
   output logic                      ram_we,
   output logic [INDEX_W-1:0]        ram_w_index,
   output logic [LINE_W-1:0]         ram_data_in,
   output logic                      refill_done,
   output logic [BEATS*WORD_W-1:0]   refill_line,
   output logic                      inv_done,
   output logic                      burst_err
);
   state_t state, state_nx;
   logic [TAG_W-1:0] tag;
   logic [INDEX_W-1:0] index, sweep_cnt;
   logic [CNT_W-1:0] beat_cnt;
   logic [BEATS*WORD_W-1:0] line;
   logic beat, last_beat, accept, unused;
   assign beat = state == RECV && mem_rd_valid;
   assign last_beat = beat_cnt == CNT_W'(BEATS - 1);
   assign accept = state == IDLE && !inv_req && miss_req;
   assign unused = ^miss_addr[OFFSET_W-1:0];
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = inv_req ? INV : miss_req ? REQ : IDLE;
         REQ:     state_nx = mem_rd_ready ? RECV : REQ;
         RECV:    state_nx = beat && last_beat ? WRITE : RECV;
         WRITE:   state_nx = IDLE;
         INV:     state_nx = sweep_cnt == '1 ? IDLE : INV;
         default: state_nx = IDLE;
      endcase
   end
   // The beat counter, not mem_rd_last, ends the burst; a misplaced last only flags burst_err.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tag       <= '0;
         index     <= '0;
         beat_cnt  <= '0;
         sweep_cnt <= '0;
         line      <= '0;
         burst_err <= 1'b0;
      end else begin
         if (accept) begin
            tag   <= miss_addr[31 -: TAG_W];
            index <= miss_addr[OFFSET_W +: INDEX_W];
         end
         if (beat) begin
            line[beat_cnt*WORD_W +: WORD_W] <= mem_rd_data;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (last_beat != mem_rd_last) burst_err <= 1'b1;
         end
         if (state == INV) sweep_cnt <= sweep_cnt + INDEX_W'(1);
      end
   always_comb begin
      miss_ready  = state == IDLE;
      mem_rd_req  = state == REQ;
      mem_rd_addr = state == REQ ? {tag, index, OFFSET_W'(0)} : '0;
      ram_we      = state == WRITE || state == INV;
      ram_w_index = state == WRITE ? index : state == INV ? sweep_cnt : '0;
      ram_data_in = '0;
      if (state == WRITE) begin
         ram_data_in[VALID_BIT]         = 1'b1;
         ram_data_in[TAG_MSB:TAG_LSB]   = tag;
         ram_data_in[TAG_LSB-1:0]       = line;
      end
      refill_done = state == WRITE;
      refill_line = state == WRITE ? line : '0;
      inv_done    = state == INV && sweep_cnt == '1;
   end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed and random refill/invalidate scenarios against a line-level model.
module tb_cache_refill_ctrl;
   import cache_pkg::*;
   logic clk = 1'b0, rst = 1'b0;
   logic miss_req = 1'b0, inv_req = 1'b0, mem_rd_ready = 1'b0, mem_rd_valid = 1'b0, mem_rd_last = 1'b0;
   logic [31:0] miss_addr = '0;
   logic [WORD_W-1:0] mem_rd_data = '0;
   logic miss_ready, mem_rd_req, ram_we, refill_done, inv_done, burst_err;
   logic [31:0] mem_rd_addr;
   logic [INDEX_W-1:0] ram_w_index;
   logic [LINE_W-1:0] ram_data_in;
   logic [BEATS*WORD_W-1:0] refill_line;
   int n_chk = 0, n_fail = 0, wr_cnt = 0;
   int gap[4];
   logic [31:0] wd[4];
   int last_pos;
   logic exp_err = 1'b0;

   cache_refill_ctrl dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
      .inv_req(inv_req), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .mem_rd_last(mem_rd_last), .ram_we(ram_we), .ram_w_index(ram_w_index),
      .ram_data_in(ram_data_in), .refill_done(refill_done), .refill_line(refill_line),
      .inv_done(inv_done), .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (ram_we === 1'b1) wr_cnt++;
   end

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one refill; abort < BEATS stops before that beat is delivered.
   task automatic do_miss(input logic [31:0] addr, input int rdly, input int abort);
      logic [127:0] line;
      logic [LINE_W-1:0] exp_line;
      int w0;
      line = {wd[3], wd[2], wd[1], wd[0]};
      exp_line = {1'b1, addr[31:10], line};
      w0 = wr_cnt;
      chk("idle_ready", miss_ready, 1);
      miss_req = 1'b1;
      miss_addr = addr;
      @(negedge clk);
      miss_req = 1'b0;
      miss_addr = $urandom;
      for (int d = 0; d <= rdly; d++) begin
         chk("rd_req", mem_rd_req, 1);
         chk("rd_addr", mem_rd_addr, {addr[31:4], 4'h0});
         chk("busy_ready", miss_ready, 0);
         mem_rd_ready = (d == rdly);
         @(negedge clk);
      end
      mem_rd_ready = 1'b0;
      chk("req_drop", mem_rd_req, 0);
      for (int b = 0; b < 4; b++) begin
         if (b == abort) return;
         for (int g = 0; g < gap[b]; g++) begin
            mem_rd_valid = 1'b0;
            mem_rd_data = $urandom;
            mem_rd_last = 1'($urandom);
            @(negedge clk);
         end
         mem_rd_valid = 1'b1;
         mem_rd_data = wd[b];
         mem_rd_last = (b == last_pos);
         if ((b == last_pos) != (b == 3)) exp_err = 1'b1;
         @(negedge clk);
      end
      mem_rd_valid = 1'b0;
      mem_rd_last = 1'b0;
      chk("wr_we", ram_we, 1);
      chk("wr_index", ram_w_index, addr[9:4]);
      chk("wr_data", ram_data_in, exp_line);
      chk("refill_done", refill_done, 1);
      chk("refill_line", refill_line, line);
      chk("burst_err", burst_err, exp_err);
      @(negedge clk);
      chk("post_we", ram_we, 0);
      chk("post_done", refill_done, 0);
      chk("post_ready", miss_ready, 1);
      chk("wr_count", wr_cnt - w0, 1);
   endtask

   task automatic do_inv();
      int w0;
      w0 = wr_cnt;
      inv_req = 1'b1;
      miss_req = 1'b1;
      miss_addr = $urandom;
      @(negedge clk);
      miss_req = 1'b0;
      for (int i = 0; i < 64; i++) begin
         chk("inv_we", ram_we, 1);
         chk("inv_index", ram_w_index, i);
         chk("inv_data", ram_data_in, 0);
         chk("inv_done", inv_done, i == 63);
         chk("inv_ready", miss_ready, 0);
         inv_req = (i < 63) ? 1'($urandom) : 1'b0;
         @(negedge clk);
      end
      chk("inv_end_we", ram_we, 0);
      chk("inv_end_done", inv_done, 0);
      chk("inv_end_ready", miss_ready, 1);
      chk("inv_count", wr_cnt - w0, 64);
   endtask

   task automatic set_beats(input int g0, input int g1, input int g2, input int g3, input int lp);
      gap[0] = g0; gap[1] = g1; gap[2] = g2; gap[3] = g3;
      last_pos = lp;
   endtask

   initial begin
      int w0;
      wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hA1A1_A1A1; wd[2] = 32'hA2A2_A2A2; wd[3] = 32'hA3A3_A3A3;
      repeat (3) @(negedge clk);
      chk("rst_we", ram_we, 0);
      chk("rst_req", mem_rd_req, 0);
      chk("rst_err", burst_err, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", miss_ready, 1);
      chk("rel_data", ram_data_in, 0);
      set_beats(0, 0, 0, 0, 3);
      do_miss(32'h1234_5670, 0, 4);
      do_miss(32'h1234_5670, 5, 4);
      set_beats(0, 0, 2, 1, 3);
      do_miss(32'h1234_5670, 0, 4);
      do_inv();
      set_beats(0, 0, 0, 0, 3);
      do_miss(32'hCAFE_0010, 1, 4);
      set_beats(0, 1, 0, 0, 1);
      do_miss(32'h8000_03F0, 0, 4);
      set_beats(0, 0, 0, 0, 3);
      do_miss(32'h0000_0400, 0, 4);
      for (int k = 0; k < 20; k++) begin
         for (int b = 0; b < 4; b++) wd[b] = $urandom;
         set_beats($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 3);
         if ($urandom_range(0, 7) == 0) do_inv();
         do_miss($urandom, $urandom_range(0, 3), 4);
      end
      set_beats(0, 0, 0, 0, 3);
      do_miss(32'h5555_AAA0, 0, 3);
      w0 = wr_cnt;
      rst = 1'b0;
      #1;
      exp_err = 1'b0;
      chk("abort_we", ram_we, 0);
      chk("abort_req", mem_rd_req, 0);
      chk("abort_done", refill_done, 0);
      chk("abort_err", burst_err, 0);
      chk("abort_data", ram_data_in, 0);
      repeat (2) @(negedge clk);
      mem_rd_valid = 1'b1;
      mem_rd_data = $urandom;
      @(negedge clk);
      mem_rd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_wr_count", wr_cnt - w0, 0);
      for (int b = 0; b < 4; b++) wd[b] = $urandom;
      do_miss(32'h5555_AAA0, 2, 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
